operand_regfile: RTL
====================

# operand_regfile

Register file and operand-select stage for the single-cycle CPU. Holds the 32 architectural registers, supplies the ALU's `A` and `B` operands (register or extended immediate), and accepts the ALU/memory write-back result on the clock edge. Sits directly upstream of the ALU and closes the write-back loop from its `result` output.

## Interface
Parameters:
- `DATA_W`, 32, register and operand width
- `ADDR_W`, 5, register index width (2^ADDR_W registers)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `rs_addr`  in  ADDR_W  source register index for operand A
- `rt_addr`  in  ADDR_W  source register index for operand B / store data
- `imm`  in  16  instruction immediate field
- `ext_sign`  in  1  1 = sign-extend `imm`, 0 = zero-extend
- `alu_src`  in  1  1 = `B` takes extended immediate, 0 = `B` takes rt value
- `we`  in  1  write-back enable
- `wr_addr`  in  ADDR_W  write-back destination index
- `wr_data`  in  DATA_W  write-back value (ALU result or load data)
- `A`  out  DATA_W  ALU operand A
- `B`  out  DATA_W  ALU operand B
- `rt_data`  out  DATA_W  raw rt value, for store data
- `dbg_addr`  in  ADDR_W  debug read index
- `dbg_data`  out  DATA_W  debug read value (no bypass)
- `wr_count`  out  32  count of committed writes since reset

## Operation
- Storage: 32 x DATA_W registers. Register 0 reads as 0 always; writes to it are dropped and not counted.
- Reads are combinational on `rs_addr`, `rt_addr`, `dbg_addr`.
- Write: on rising `clk`, if `!rst && we && wr_addr != 0`, the register at `wr_addr` takes `wr_data` and `wr_count` increments by 1.
- Bypass: if `we && wr_addr != 0 && wr_addr == rs_addr`, then `A = wr_data` in the same cycle. The same rule applies to `rt_addr` for `rt_data` and for `B` when `alu_src = 0`. `dbg_data` is never bypassed and shows only committed state.
- Immediate extension: sign mode gives `{{16{imm[15]}}, imm}`; zero mode gives `{16'h0, imm}`.
- `B = alu_src ? ext_imm : rt_value`, where `rt_value` is the bypassed rt read.
- Reset: while `rst` is high at a rising edge, all registers and `wr_count` clear to 0. `we` is ignored in that cycle because reset wins.
- `wr_count` wraps from 0xFFFFFFFF to 0.

## Timing
- Reset values: all registers 0 and `wr_count` = 0, so with bypass inactive `A`, `rt_data` and `dbg_data` read 0, and `B` reads 0 unless an immediate is selected.
- Read latency is 0 cycles (combinational). A write becomes visible to non-bypassed reads one edge later and to bypassed reads in the same cycle.
- Simultaneous read of the same register on both ports gives both ports the same value, bypass included.
- If `rst` is asserted mid-program, state clears on that edge. In the first cycle after `rst` deasserts, writes proceed normally.
- Combinational path from `wr_data` through the bypass to `A`/`B` is permitted; single-cycle timing closure is the top-level's concern.

## Structure
- Shared package `cpu_pkg`: `DATA_W`, `ADDR_W`, `REG_ZERO = 0`, `ALU_SRC_REG/ALU_SRC_IMM`, `EXT_ZERO/EXT_SIGN` constants. The ALU op encodings also belong there.
- One sub-module, `imm_extend` (16 to 32 bits, sign/zero), reused later by branch-offset logic.
- Register array, bypass compare and write counter stay in this module.

## Test plan
- Reset then read: pulse `rst` 1 cycle; `rs_addr = 5`, `rt_addr = 31`, `alu_src = 0` -> `A = 0`, `B = 0`, `wr_count = 0`.
- Write then read: `we = 1`, `wr_addr = 3`, `wr_data = 0xDEADBEEF`, then `rs_addr = 3` next cycle -> `A = 0xDEADBEEF`, `dbg_data(3) = 0xDEADBEEF`, `wr_count = 1`.
- $0 immutability: write 0x12345678 to reg 0 -> `A` (rs = 0) = 0, `wr_count` unchanged.
- Same-cycle bypass: reg 7 = 0x1, then `we = 1`, `wr_addr = 7`, `wr_data = 0x55`, `rs_addr = rt_addr = 7` -> `A = B = rt_data = 0x55` in that cycle, `dbg_data(7) = 0x1` until the edge.
- Immediate select: `imm = 0x8001`, `alu_src = 1`; `ext_sign = 1` -> `B = 0xFFFF8001`; `ext_sign = 0` -> `B = 0x00008001`; `rt_data` still equals the rt register value.
- Reset wins over write: reg 4 = 0xAA, then `rst = 1` with `we = 1`, `wr_addr = 4`, `wr_data = 0xBB` -> after the edge reg 4 = 0, `wr_count = 0`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, register-zero index, operand-select
// and extension-mode encodings, and the ALU operation encodings.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int IMM_W  = 16;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    localparam logic ALU_SRC_REG = 1'b0;
    localparam logic ALU_SRC_IMM = 1'b1;

    localparam logic EXT_ZERO = 1'b0;
    localparam logic EXT_SIGN = 1'b1;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOR = 4'd5,
        ALU_SLT = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_SRA = 4'd9,
        ALU_LUI = 4'd10
    } alu_op_e;

endpackage

// File: rtl/imm_extend.sv
// 16-bit immediate to OUT_W-bit operand, sign- or zero-extended. Also intended
// for branch-offset generation, hence kept as its own block.
module imm_extend
    import cpu_pkg::*;
#(
    parameter int OUT_W = 32
) (
    input  logic [15:0]      imm,
    input  logic             ext_sign,
    output logic [OUT_W-1:0] ext_imm
);

    // Select extension mode; an undefined mode falls back to zero extension
    always_comb begin
        ext_imm = {OUT_W{1'b0}};
        case (ext_sign)
            EXT_SIGN: ext_imm = {{(OUT_W-16){imm[15]}}, imm};
            EXT_ZERO: ext_imm = {{(OUT_W-16){1'b0}}, imm};
            default:  ext_imm = {{(OUT_W-16){1'b0}}, imm};
        endcase
    end

endmodule

// File: rtl/operand_regfile.sv
// Architectural register file with same-cycle write-back bypass, ALU operand
// selection (register or extended immediate) and a committed-write counter.
module operand_regfile #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [15:0]       imm,
    input  logic              ext_sign,
    input  logic              alu_src,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] rt_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [31:0]       wr_count
);

    import cpu_pkg::*;

    localparam int                NUM_REGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_r [NUM_REGS];
    logic [31:0]       wr_count_r;

    logic              wr_hit_s;
    logic              wr_commit_s;
    logic [DATA_W-1:0] rs_raw_s;
    logic [DATA_W-1:0] rt_raw_s;
    logic [DATA_W-1:0] dbg_raw_s;
    logic [DATA_W-1:0] rs_val_s;
    logic [DATA_W-1:0] rt_val_s;
    logic [DATA_W-1:0] ext_imm_s;
    logic [DATA_W-1:0] b_s;

    imm_extend #(
        .OUT_W (DATA_W)
    ) u_imm_extend (
        .imm      (imm),
        .ext_sign (ext_sign),
        .ext_imm  (ext_imm_s)
    );

    // Write-back qualifiers; bypass ignores rst, the commit does not
    always_comb begin
        wr_hit_s    = we && (wr_addr != ZERO_IDX);
        wr_commit_s = wr_hit_s && !rst;
    end

    // Register array and write counter; reset wins over a pending write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
            wr_count_r <= 32'd0;
        end else if (wr_commit_s) begin
            regs_r[wr_addr] <= wr_data;
            wr_count_r      <= wr_count_r + 32'd1;
        end else begin
            wr_count_r <= wr_count_r;
        end
    end

    // Committed-state reads; index zero is forced to zero independent of storage
    always_comb begin
        rs_raw_s  = regs_r[rs_addr];
        rt_raw_s  = regs_r[rt_addr];
        dbg_raw_s = regs_r[dbg_addr];
        if (rs_addr == ZERO_IDX) begin
            rs_raw_s = {DATA_W{1'b0}};
        end else begin
            rs_raw_s = regs_r[rs_addr];
        end
        if (rt_addr == ZERO_IDX) begin
            rt_raw_s = {DATA_W{1'b0}};
        end else begin
            rt_raw_s = regs_r[rt_addr];
        end
        if (dbg_addr == ZERO_IDX) begin
            dbg_raw_s = {DATA_W{1'b0}};
        end else begin
            dbg_raw_s = regs_r[dbg_addr];
        end
    end

    // Same-cycle bypass of the write-back value onto the source reads
    always_comb begin
        rs_val_s = rs_raw_s;
        rt_val_s = rt_raw_s;
        if (wr_hit_s && (wr_addr == rs_addr)) begin
            rs_val_s = wr_data;
        end else begin
            rs_val_s = rs_raw_s;
        end
        if (wr_hit_s && (wr_addr == rt_addr)) begin
            rt_val_s = wr_data;
        end else begin
            rt_val_s = rt_raw_s;
        end
    end

    // Operand B source select
    always_comb begin
        b_s = rt_val_s;
        case (alu_src)
            ALU_SRC_IMM: b_s = ext_imm_s;
            ALU_SRC_REG: b_s = rt_val_s;
            default:     b_s = rt_val_s;
        endcase
    end

    // Drive outputs; dbg_data deliberately shows committed state only
    always_comb begin
        A        = rs_val_s;
        B        = b_s;
        rt_data  = rt_val_s;
        dbg_data = dbg_raw_s;
        wr_count = wr_count_r;
    end

endmodule
